sd_sec_read: RTL and testbench

SPI-mode SD card single-sector reader. Accepts a sector start request, issues CMD17 over SPI and streams the 512-byte payload out as 256 16-bit words on the rd_busy / rd_val_en / rd_val_data interface. This is the interface consumed by the boot controller that copies sectors into instruction memory. It sits between the SD SPI pins (through the top-level init/read bus mux) and that boot controller.

---
 rtl/sd_pkg.sv | 51 +++++
 rtl/sd_crc16.sv | 53 +++++
 rtl/sd_sec_read.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sd_sec_read.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared constants, reader state encoding and the CMD17 frame
//               helper for the SPI-mode SD sector reader.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    // SD command / token bytes
    localparam logic [7:0]  c_CMD17       = 8'h51;
    localparam logic [7:0]  c_DATA_TOKEN  = 8'hFE;
    localparam logic [7:0]  c_IDLE_BYTE   = 8'hFF;

    // Sector geometry
    localparam int          c_SECTOR_BYTES = 512;
    localparam int          c_SECTOR_WORDS = 256;

    // CRC16-CCITT generator polynomial
    localparam logic [15:0] c_CRC16_POLY  = 16'h1021;

    // Reader state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RESP  = 3'd2,
        ST_TOKEN = 3'd3,
        ST_DATA  = 3'd4,
        ST_CRC   = 3'd5,
        ST_TAIL  = 3'd6,
        ST_ERR   = 3'd7
    } rd_state_e;

    // Byte idx (0..5) of the CMD17 frame: opcode, 4 address bytes MSB first,
    // and a dummy CRC byte (CRC is ignored by the card in SPI mode).
    function automatic logic [7:0] cmd_frame_byte(input logic [31:0] addr,
                                                  input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = c_CMD17;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            default: b = c_IDLE_BYTE;
        endcase
        return b;
    endfunction

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16
// Description : Bit-serial CRC16-CCITT (poly 0x1021, init 0), MSB first.
//               Only built when SD_RD_CRC_CHECK_EN is defined, since it is
//               instantiated solely by the reader's CRC check.
// Ports       : clk    - system clock
//               rst_n  - synchronous active-low reset
//               clr    - clear the remainder to 0
//               en     - shift in one data bit
//               din    - data bit
//               crc    - current remainder
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef SD_RD_CRC_CHECK_EN
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        w_fb;

    always_comb begin
        w_fb  = crc_q[15] ^ din;
        crc_d = crc_q;
        if (clr) begin
            crc_d = 16'h0000;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (w_fb ? c_CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule : sd_crc16
`endif
`default_nettype wire

// File: rtl/sd_sec_read.sv
`default_nettype none
// ============================================================================
// Module      : sd_sec_read
// Description : SPI-mode SD single-sector reader. On a rising edge of
//               rd_start_en (card initialised, reader idle) it sends CMD17,
//               waits for R1 and the 0xFE data token, then streams the 512
//               payload bytes out as 256 16-bit words.
// Parameters  : CLK_DIV     - SPI half-period in clk cycles (>= 1)
//               RESP_POLLS  - max poll bytes while waiting for R1
//               TOKEN_POLLS - max poll bytes while waiting for the data token
// Options     : SD_RD_CRC_CHECK_EN - check CRC16 of the payload; a mismatch
//               sets rd_err. Undefined: CRC bytes are discarded.
// Ports       : clk, rst_n (sync, active-low)
//               sd_init_done, rd_start_en, rd_sec_addr    - request side
//               rd_busy, rd_val_en, rd_val_data, rd_err   - result side
//               sd_cs, sd_sclk, sd_mosi, sd_miso          - SPI mode 0 pins
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sec_read
    import sd_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int RESP_POLLS  = 8,
    parameter int TOKEN_POLLS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_err,
    output logic        sd_cs,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    localparam int               c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [12:0]      c_RESP_LAST  = 13'(RESP_POLLS - 1);
    localparam logic [12:0]      c_TOKEN_LAST = 13'(TOKEN_POLLS - 1);
    localparam logic [9:0]       c_LAST_DATA  = 10'(c_SECTOR_BYTES - 1);

    rd_state_e            state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [9:0]           byte_q, byte_d;
    logic [12:0]          poll_q, poll_d;
    logic [7:0]           tx_q, tx_d;     // tx_q[7] is the MOSI pin
    logic [7:0]           rx_q, rx_d;
    logic [31:0]          addr_q, addr_d;
    logic [7:0]           hi_q, hi_d;     // first (upper) byte of current word
    logic                 start_prev_q;
    logic                 busy_q, busy_d;
    logic                 val_en_q, val_en_d;
    logic [15:0]          val_data_q, val_data_d;
    logic                 err_q, err_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;

    logic                 w_tick;
    logic                 w_trigger;
    logic [7:0]           w_rx_full;
    logic [7:0]           w_next_byte;
    logic                 w_go_err;

`ifdef SD_RD_CRC_CHECK_EN
    logic [7:0]           crc_hi_q, crc_hi_d;
    logic [15:0]          w_crc;
    logic                 w_crc_en;

    // Payload bits enter the CRC as they are sampled on rising SCLK.
    assign w_crc_en = w_tick & ~sclk_q & (state_q == ST_DATA);

    sd_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_trigger),
        .en    (w_crc_en),
        .din   (sd_miso),
        .crc   (w_crc)
    );
`endif

    assign w_tick    = (div_q == c_DIV_MAX);
    assign w_trigger = rd_start_en & ~start_prev_q & sd_init_done & (state_q == ST_IDLE);
    assign w_rx_full = {rx_q[6:0], sd_miso};

    // Rising SCLK samples MISO and emits completed words; falling SCLK shifts
    // MOSI and, on the last bit of a byte, makes all per-byte state decisions
    // using the fully assembled rx_q.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        poll_d      = poll_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        busy_d      = busy_q;
        val_en_d    = 1'b0;
        val_data_d  = val_data_q;
        err_d       = err_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        w_next_byte = c_IDLE_BYTE;
        w_go_err    = 1'b0;
`ifdef SD_RD_CRC_CHECK_EN
        crc_hi_d    = crc_hi_q;
`endif

        if (state_q == ST_IDLE) begin
            div_d = '0;
            if (w_trigger) begin
                state_d = ST_CMD;
                busy_d  = 1'b1;
                cs_d    = 1'b0;
                err_d   = 1'b0;
                addr_d  = rd_sec_addr;
                tx_d    = c_CMD17;      // first MOSI bit set up before first rise
                sclk_d  = 1'b0;
                bit_d   = 3'd0;
                byte_d  = 10'd0;
                poll_d  = 13'd0;
            end
        end else begin
            div_d = w_tick ? '0 : div_q + 1'b1;
            if (w_tick) begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = w_rx_full;
                    if (bit_q == 3'd7) begin
                        if (state_q == ST_DATA) begin
                            if (!byte_q[0]) begin
                                hi_d = w_rx_full;
                            end else begin
                                val_en_d   = 1'b1;
                                val_data_d = {hi_q, w_rx_full};
                            end
                        end
`ifdef SD_RD_CRC_CHECK_EN
                        if (state_q == ST_CRC && !byte_q[0]) begin
                            crc_hi_d = w_rx_full;
                        end
`endif
                    end
                end else begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 3'd1;
                    tx_d   = {tx_q[6:0], 1'b1};
                    if (bit_q == 3'd7) begin
                        byte_d = byte_q + 10'd1;
                        case (state_q)
                            ST_CMD: begin
                                if (byte_q == 10'd5) begin
                                    state_d = ST_RESP;
                                    byte_d  = 10'd0;
                                    poll_d  = 13'd0;
                                end else begin
                                    w_next_byte = cmd_frame_byte(addr_q, byte_q[2:0] + 3'd1);
                                end
                            end
                            ST_RESP: begin
                                if (!rx_q[7]) begin
                                    if (rx_q == 8'h00) begin
                                        state_d = ST_TOKEN;
                                        poll_d  = 13'd0;
                                    end else begin
                                        w_go_err = 1'b1;
                                    end
                                end else if (poll_q == c_RESP_LAST) begin
                                    w_go_err = 1'b1;
                                end else begin
                                    poll_d = poll_q + 13'd1;
                                end
                            end
                            ST_TOKEN: begin
                                if (rx_q == c_DATA_TOKEN) begin
                                    state_d = ST_DATA;
                                    byte_d  = 10'd0;
                                end else if (rx_q[7:4] == 4'h0) begin
                                    w_go_err = 1'b1;  // data error token
                                end else if (poll_q == c_TOKEN_LAST) begin
                                    w_go_err = 1'b1;
                                end else begin
                                    poll_d = poll_q + 13'd1;
                                end
                            end
                            ST_DATA: begin
                                if (byte_q == c_LAST_DATA) begin
                                    state_d = ST_CRC;
                                    byte_d  = 10'd0;
                                end
                            end
                            ST_CRC: begin
                                if (byte_q[0]) begin
                                    state_d = ST_TAIL;
                                    cs_d    = 1'b1;
`ifdef SD_RD_CRC_CHECK_EN
                                    if ({crc_hi_q, rx_q} != w_crc) begin
                                        err_d = 1'b1;
                                    end
`endif
                                end
                            end
                            ST_TAIL, ST_ERR: begin
                                // 8 idle clocks with CS high are done
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                            default: begin
                                state_d = ST_IDLE;
                            end
                        endcase
                        if (w_go_err) begin
                            state_d = ST_ERR;
                            cs_d    = 1'b1;
                            err_d   = 1'b1;
                        end
                        tx_d = w_next_byte;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= 3'd0;
            byte_q       <= 10'd0;
            poll_q       <= 13'd0;
            tx_q         <= c_IDLE_BYTE;
            rx_q         <= 8'h00;
            addr_q       <= 32'h0;
            hi_q         <= 8'h00;
            start_prev_q <= 1'b0;
            busy_q       <= 1'b0;
            val_en_q     <= 1'b0;
            val_data_q   <= 16'h0000;
            err_q        <= 1'b0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
`ifdef SD_RD_CRC_CHECK_EN
            crc_hi_q     <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            poll_q       <= poll_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            start_prev_q <= rd_start_en;
            busy_q       <= busy_d;
            val_en_q     <= val_en_d;
            val_data_q   <= val_data_d;
            err_q        <= err_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
`ifdef SD_RD_CRC_CHECK_EN
            crc_hi_q     <= crc_hi_d;
`endif
        end
    end

    assign rd_busy     = busy_q;
    assign rd_val_en   = val_en_q;
    assign rd_val_data = val_data_q;
    assign rd_err      = err_q;
    assign sd_cs       = cs_q;
    assign sd_sclk     = sclk_q;
    assign sd_mosi     = tx_q[7];

endmodule : sd_sec_read
`default_nettype wire

// File: tb/tb_sd_sec_read.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_sec_read
// Description : Self-checking bench for sd_sec_read with a behavioural SPI
//               SD card model and a word scoreboard. Honours
//               SD_RD_CRC_CHECK_EN for the corrupted-CRC case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sec_read;
    import sd_pkg::*;

    localparam int c_CLK_DIV = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sd_init_done;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_err;
    logic        sd_cs;
    logic        sd_sclk;
    logic        sd_mosi;
    logic        sd_miso = 1'b1;

    sd_sec_read #(
        .CLK_DIV     (c_CLK_DIV),
        .RESP_POLLS  (8),
        .TOKEN_POLLS (4096)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .rd_busy      (rd_busy),
        .rd_val_en    (rd_val_en),
        .rd_val_data  (rd_val_data),
        .rd_err       (rd_err),
        .sd_cs        (sd_cs),
        .sd_sclk      (sd_sclk),
        .sd_mosi      (sd_mosi),
        .sd_miso      (sd_miso)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- card scenario ----------------
    logic [7:0]  sc_r1  = 8'h00;
    int          sc_tok = 10;
    bit          sc_bad = 1'b0;
    logic [15:0] exp_crc;

    function automatic logic [15:0] calc_crc();
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int i = 0; i < c_SECTOR_BYTES; i++) begin
            b = 8'(i);
            c = c ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) begin
                if (c[15]) c = (c << 1) ^ 16'h1021;
                else       c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] stream_byte(input int k);
        int j;
        if (k < 6) return 8'hFF;
        j = k - 6;
        if (j < 2)  return 8'hFF;
        if (j == 2) return sc_r1;
        if (sc_r1 != 8'h00) return 8'hFF;
        j = j - 3;
        if (j < sc_tok)  return 8'hFF;
        if (j == sc_tok) return 8'hFE;
        j = j - sc_tok - 1;
        if (j < c_SECTOR_BYTES) return 8'(j);
        if (j == c_SECTOR_BYTES)     return exp_crc[15:8];
        if (j == c_SECTOR_BYTES + 1) return exp_crc[7:0] ^ {7'd0, sc_bad};
        return 8'hFF;
    endfunction

    function automatic logic stream_bit(input int n);
        logic [7:0] b;
        b = stream_byte(n / 8);
        return b[7 - (n % 8)];
    endfunction

    // ---------------- card model ----------------
    int          rcnt      = 0;
    int          last_rcnt = 0;
    int          tail_cnt  = 0;
    logic [47:0] frame     = '0;
    logic        card_sclk_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!sd_cs) begin
                tail_cnt = 0;
                if (sd_sclk && !card_sclk_prev) begin
                    if (rcnt < 48) frame = {frame[46:0], sd_mosi};
                    rcnt++;
                end
                sd_miso = stream_bit(rcnt);
            end else begin
                if (sd_sclk && !card_sclk_prev) tail_cnt++;
                if (rcnt != 0) begin
                    last_rcnt = rcnt;
                    rcnt      = 0;
                end
                sd_miso = 1'b1;
            end
            card_sclk_prev = sd_sclk;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    int          tx_strobes  = 0;
    int          n_busy_rise = 0;
    logic        busy_prev   = 1'b0;
    longint      cyc         = 0;
    longint      last_strobe = -1;
    longint      min_gap     = 1000000;
    logic [15:0] first_word  = '0;
    logic [15:0] last_word   = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_busy && !busy_prev) n_busy_rise++;
            busy_prev = rd_busy;
            if (rd_val_en) begin
                if (tx_strobes == 0) first_word = rd_val_data;
                last_word = rd_val_data;
                if (last_strobe >= 0 && (cyc - last_strobe) < min_gap) min_gap = cyc - last_strobe;
                last_strobe = cyc;
                tx_strobes++;
                if (exp_q.size() == 0) begin
                    chk("strobe_with_empty_queue", rd_val_en, 1'b0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", rd_val_data, exp_w);
                end
            end
        end
    end

    task automatic push_sector();
        logic [7:0] a, b;
        for (int w = 0; w < c_SECTOR_WORDS; w++) begin
            a = 8'(2 * w);
            b = 8'(2 * w + 1);
            exp_q.push_back({a, b});
        end
    endtask

    // Raise rd_start_en (caller ensures it was low) and check the trigger edge.
    task automatic launch(input logic [31:0] addr);
        @(negedge clk);
        rd_sec_addr = addr;
        rd_start_en = 1'b1;
        tx_strobes  = 0;
        last_strobe = -1;
        @(posedge clk);
        #1;
        chk("busy_after_trigger", rd_busy, 1'b1);
        chk("cs_after_trigger", sd_cs, 1'b0);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c;
        c = 0;
        while (rd_busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_in_budget"}, rd_busy, 1'b0);
    endtask

    int base_rise;

    initial begin
        rst_n        = 1'b0;
        sd_init_done = 1'b1;
        rd_start_en  = 1'b0;
        rd_sec_addr  = 32'h0;
        exp_crc      = calc_crc();
        repeat (3) @(negedge clk);
        chk("rst_busy",  rd_busy, 1'b0);
        chk("rst_val",   rd_val_en, 1'b0);
        chk("rst_data",  rd_val_data, 16'h0000);
        chk("rst_err",   rd_err, 1'b0);
        chk("rst_cs",    sd_cs, 1'b1);
        chk("rst_sclk",  sd_sclk, 1'b0);
        chk("rst_mosi",  sd_mosi, 1'b1);
        rst_n = 1'b1;

        // Request ignored while card not initialised
        @(negedge clk);
        sd_init_done = 1'b0;
        rd_start_en  = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_init_ignored", rd_busy, 1'b0);
        rd_start_en  = 1'b0;
        sd_init_done = 1'b1;
        repeat (2) @(negedge clk);

        // A: normal read, retrigger while busy, start held high at the end
        sc_r1 = 8'h00; sc_tok = 10; sc_bad = 1'b0;
        push_sector();
        base_rise = n_busy_rise;
        launch(32'h1234_5678);
        repeat (50) @(negedge clk);
        rd_start_en = 1'b0;
        repeat (5) @(negedge clk);
        rd_start_en = 1'b1;
        wait_idle(20000, "A");
        chk("A_strobes", tx_strobes, 256);
        chk("A_first_word", first_word, 16'h0001);
        chk("A_last_word", last_word, 16'hFEFF);
        chk("A_err", rd_err, 1'b0);
        chk("A_frame", frame, {8'h51, 32'h1234_5678, 8'hFF});
        chk("A_queue_empty", exp_q.size(), 0);
        chk("A_min_gap_ok", (min_gap >= 16 * c_CLK_DIV), 1'b1);
        repeat (40) @(negedge clk);
        chk("A_no_retrigger_busy", rd_busy, 1'b0);
        chk("A_one_transaction", n_busy_rise - base_rise, 1);

        // B: R1 error, then trigger in the first cycle after rd_busy falls
        rd_start_en = 1'b0;
        repeat (2) @(negedge clk);
        sc_r1 = 8'h04;
        launch(32'h0000_4100);
        rd_start_en = 1'b0;
        wait_idle(2000, "B");
        chk("B_err", rd_err, 1'b1);
        chk("B_strobes", tx_strobes, 0);
        chk("B_cs_high", sd_cs, 1'b1);
        chk("B_tail_clocks", tail_cnt, 8);
        chk("B_frame", frame, 48'h51_0000_4100_FF);
        chk("B_bits_with_cs_low", last_rcnt, 8 * 9);
        sc_r1 = 8'h00; sc_tok = 10;
        push_sector();
        tx_strobes  = 0;
        last_strobe = -1;
        rd_start_en = 1'b1;
        @(posedge clk);
        #1;
        chk("C_retrigger_accepted", rd_busy, 1'b1);
        chk("C_err_cleared", rd_err, 1'b0);

        // C: reset during DATA word 100
        begin
            int c;
            c = 0;
            while (tx_strobes < 100 && c < 20000) begin
                @(negedge clk);
                c++;
            end
            chk("C_reached_word_100", tx_strobes, 100);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("C_rst_busy", rd_busy, 1'b0);
        chk("C_rst_val", rd_val_en, 1'b0);
        chk("C_rst_data", rd_val_data, 16'h0000);
        chk("C_rst_err", rd_err, 1'b0);
        chk("C_rst_cs", sd_cs, 1'b1);
        chk("C_rst_sclk", sd_sclk, 1'b0);
        chk("C_rst_mosi", sd_mosi, 1'b1);
        @(negedge clk);
        rd_start_en = 1'b0;
        rst_n       = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("C_idle_after_reset", rd_busy, 1'b0);

        // D: token never arrives
        sc_r1 = 8'h00; sc_tok = 1 << 20;
        launch(32'h0000_0007);
        rd_start_en = 1'b0;
        wait_idle(80000, "D");
        chk("D_err", rd_err, 1'b1);
        chk("D_bits_with_cs_low", last_rcnt, 8 * (6 + 3 + 4096));
        chk("D_strobes", tx_strobes, 0);
        chk("D_tail_clocks", tail_cnt, 8);

`ifdef SD_RD_CRC_CHECK_EN
        // E: corrupted CRC byte
        sc_r1 = 8'h00; sc_tok = 3; sc_bad = 1'b1;
        push_sector();
        launch(32'h0000_0100);
        rd_start_en = 1'b0;
        wait_idle(20000, "E");
        chk("E_strobes", tx_strobes, 256);
        chk("E_crc_err", rd_err, 1'b1);
        sc_bad = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sd_sec_read
`default_nettype wire
